commit_unit: RTL and testbench

//  Retire end of the reservation buffer that the dispatch stage fills. Each cycle

---
 rtl/commit_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_commit_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
// Retire end of the reservation buffer. Every cycle the two oldest in-use
// entries (largest tags) are located. If they have executed they retire in
// order: register results are written back, stores are drained to data memory
// through a valid/ready handshake, and the buffer entries are released.
//
// Entry packing inside entries_all (entry i at bit i*ENTRY_W, LSB first):
//   [1:0]                  e_state : 0 S_NOT_USED, 1 S_NOT_EXECUTED, 2 S_EXECUTED
//   [3:2]                  op      : 0 ALU, 1 STORE, 2 BRANCH, 3 LOAD
//   [4 +: TAG_W]           tag     : larger tag = older instruction
//   [DEST_LSB +: 5]        Dest    : destination register
//   [RES_LSB  +: 32]       result  : ALU/load result, or store address
//   [VK_LSB   +: 32]       Vk      : store data
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   entries_all         current buffer contents, BUF_SIZE packed entries
//   flush               squash pending commits and any unaccepted store
//   rf_we/addr/data     two register-file write ports, slot 0 older
//   free_valid/index    two entry-release ports, slot 0 older
//   st_valid/ready      store request handshake
//   st_addr/st_data     store address / data, stable while st_valid is high
//   retired_cnt         running count of retired instructions (wraps)
// -----------------------------------------------------------------------------
module commit_unit #(
    parameter int BUF_SIZE     = 16,
    parameter int BUF_SIZE_LOG = 4,
    localparam int TAG_W       = BUF_SIZE_LOG + 1,
    localparam int ENTRY_W     = 4 + TAG_W + 5 + 32 + 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BUF_SIZE*ENTRY_W-1:0]   entries_all,
    input  logic                          flush,
    output logic [1:0]                    rf_we,
    output logic [9:0]                    rf_addr,
    output logic [63:0]                   rf_data,
    output logic [1:0]                    free_valid,
    output logic [2*BUF_SIZE_LOG-1:0]     free_index,
    output logic                          st_valid,
    input  logic                          st_ready,
    output logic [31:0]                   st_addr,
    output logic [31:0]                   st_data,
    output logic [31:0]                   retired_cnt
);

    localparam int STATE_LSB = 0;
    localparam int OP_LSB    = 2;
    localparam int TAG_LSB   = 4;
    localparam int DEST_LSB  = TAG_LSB + TAG_W;
    localparam int RES_LSB   = DEST_LSB + 5;
    localparam int VK_LSB    = RES_LSB + 32;

    localparam logic [1:0] S_NOT_USED     = 2'd0;
    localparam logic [1:0] S_EXECUTED     = 2'd2;

    localparam logic [1:0] OP_STORE  = 2'd1;
    localparam logic [1:0] OP_BRANCH = 2'd2;

    localparam logic [0:0] S_COMMIT     = 1'b0;
    localparam logic [0:0] S_STORE_WAIT = 1'b1;

    // Only instructions that produce a register value and target a real register write back.
    function automatic logic f_writes_rf(input logic [1:0] op, input logic [4:0] dest);
        return (op != OP_STORE) && (op != OP_BRANCH) && (dest != 5'd0);
    endfunction

    logic [1:0]        w_state [BUF_SIZE];
    logic [1:0]        w_op    [BUF_SIZE];
    logic [TAG_W-1:0]  w_tag   [BUF_SIZE];
    logic [4:0]        w_dest  [BUF_SIZE];
    logic [31:0]       w_res   [BUF_SIZE];
    logic [31:0]       w_vk    [BUF_SIZE];

    for (genvar g = 0; g < BUF_SIZE; g++) begin : g_unpack
        assign w_state[g] = entries_all[g*ENTRY_W + STATE_LSB +: 2];
        assign w_op[g]    = entries_all[g*ENTRY_W + OP_LSB    +: 2];
        assign w_tag[g]   = entries_all[g*ENTRY_W + TAG_LSB   +: TAG_W];
        assign w_dest[g]  = entries_all[g*ENTRY_W + DEST_LSB  +: 5];
        assign w_res[g]   = entries_all[g*ENTRY_W + RES_LSB   +: 32];
        assign w_vk[g]    = entries_all[g*ENTRY_W + VK_LSB    +: 32];
    end

    logic [0:0]              r_fsm;
    logic [BUF_SIZE-1:0]     r_pending;
    logic [BUF_SIZE_LOG-1:0] r_st_idx;
    logic [1:0]              r_rf_we;
    logic [9:0]              r_rf_addr;
    logic [63:0]             r_rf_data;
    logic [1:0]              r_free_valid;
    logic [2*BUF_SIZE_LOG-1:0] r_free_index;
    logic                    r_st_valid;
    logic [31:0]             r_st_addr;
    logic [31:0]             r_st_data;
    logic [31:0]             r_retired_cnt;

    logic                    w_old_found;
    logic [BUF_SIZE_LOG-1:0] w_old_idx;
    logic [TAG_W-1:0]        w_old_tag;
    logic                    w_sec_found;
    logic [BUF_SIZE_LOG-1:0] w_sec_idx;
    logic [TAG_W-1:0]        w_sec_tag;
    logic                    w_take;

    // Oldest / second-oldest search; entries released last cycle are still
    // marked used in the buffer, so the pending mask hides them.
    always_comb begin
        w_old_found = 1'b0;
        w_old_idx   = {BUF_SIZE_LOG{1'b0}};
        w_old_tag   = {TAG_W{1'b0}};
        w_sec_found = 1'b0;
        w_sec_idx   = {BUF_SIZE_LOG{1'b0}};
        w_sec_tag   = {TAG_W{1'b0}};
        w_take      = 1'b0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            w_take      = (w_state[i] != S_NOT_USED) && !r_pending[i] &&
                          (!w_old_found || (w_tag[i] > w_old_tag));
            w_old_idx   = w_take ? BUF_SIZE_LOG'(i) : w_old_idx;
            w_old_tag   = w_take ? w_tag[i] : w_old_tag;
            w_old_found = w_old_found | w_take;
        end
        for (int i = 0; i < BUF_SIZE; i++) begin
            w_take      = w_old_found && (w_state[i] != S_NOT_USED) && !r_pending[i] &&
                          (w_tag[i] < w_old_tag) &&
                          (!w_sec_found || (w_tag[i] > w_sec_tag));
            w_sec_idx   = w_take ? BUF_SIZE_LOG'(i) : w_sec_idx;
            w_sec_tag   = w_take ? w_tag[i] : w_sec_tag;
            w_sec_found = w_sec_found | w_take;
        end
    end

    logic w_old_exec;
    logic w_ret0;
    logic w_ret1;
    logic w_start_store;
    logic [BUF_SIZE-1:0] w_commit_mask;
    logic [BUF_SIZE-1:0] w_store_mask;

    assign w_old_exec    = w_old_found && (w_state[w_old_idx] == S_EXECUTED);
    assign w_ret0        = (r_fsm == S_COMMIT) && w_old_exec && (w_op[w_old_idx] != OP_STORE);
    assign w_start_store = (r_fsm == S_COMMIT) && w_old_exec && (w_op[w_old_idx] == OP_STORE);
    // A store in slot 1 must wait for its own handshake, so it never pairs.
    assign w_ret1        = w_ret0 && w_sec_found && (w_state[w_sec_idx] == S_EXECUTED) &&
                           (w_op[w_sec_idx] != OP_STORE);
    assign w_commit_mask = ({{(BUF_SIZE-1){1'b0}}, w_ret0} << w_old_idx) |
                           ({{(BUF_SIZE-1){1'b0}}, w_ret1} << w_sec_idx);
    assign w_store_mask  = {{(BUF_SIZE-1){1'b0}}, 1'b1} << r_st_idx;

    // Commit / store-drain state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm         <= S_COMMIT;
            r_pending     <= {BUF_SIZE{1'b0}};
            r_st_idx      <= {BUF_SIZE_LOG{1'b0}};
            r_rf_we       <= 2'b00;
            r_rf_addr     <= 10'd0;
            r_rf_data     <= 64'd0;
            r_free_valid  <= 2'b00;
            r_free_index  <= {(2*BUF_SIZE_LOG){1'b0}};
            r_st_valid    <= 1'b0;
            r_st_addr     <= 32'd0;
            r_st_data     <= 32'd0;
            r_retired_cnt <= 32'd0;
        end else if (flush) begin
            // An unaccepted store is dropped without being freed.
            r_fsm        <= S_COMMIT;
            r_pending    <= {BUF_SIZE{1'b0}};
            r_rf_we      <= 2'b00;
            r_free_valid <= 2'b00;
            r_st_valid   <= 1'b0;
        end else begin
            case (r_fsm)
                S_COMMIT: begin
                    r_rf_we[0]        <= w_ret0 && f_writes_rf(w_op[w_old_idx], w_dest[w_old_idx]);
                    r_rf_we[1]        <= w_ret1 && f_writes_rf(w_op[w_sec_idx], w_dest[w_sec_idx]);
                    r_rf_addr         <= {w_dest[w_sec_idx], w_dest[w_old_idx]};
                    r_rf_data         <= {w_res[w_sec_idx], w_res[w_old_idx]};
                    r_free_valid      <= {w_ret1, w_ret0};
                    r_free_index      <= {w_sec_idx, w_old_idx};
                    r_pending         <= w_commit_mask;
                    r_retired_cnt     <= r_retired_cnt + 32'(w_ret0) + 32'(w_ret1);
                    if (w_start_store) begin
                        r_st_valid <= 1'b1;
                        r_st_addr  <= w_res[w_old_idx];
                        r_st_data  <= w_vk[w_old_idx];
                        r_st_idx   <= w_old_idx;
                        r_fsm      <= S_STORE_WAIT;
                    end else begin
                        r_st_valid <= 1'b0;
                        r_fsm      <= S_COMMIT;
                    end
                end
                S_STORE_WAIT: begin
                    r_rf_we <= 2'b00;
                    if (st_ready) begin
                        r_free_valid                   <= 2'b01;
                        r_free_index[BUF_SIZE_LOG-1:0] <= r_st_idx;
                        r_pending                      <= w_store_mask;
                        r_retired_cnt                  <= r_retired_cnt + 32'd1;
                        r_st_valid                     <= 1'b0;
                        r_fsm                          <= S_COMMIT;
                    end else begin
                        r_free_valid <= 2'b00;
                        r_pending    <= {BUF_SIZE{1'b0}};
                        r_st_valid   <= 1'b1;
                        r_fsm        <= S_STORE_WAIT;
                    end
                end
                default: begin
                    r_fsm        <= S_COMMIT;
                    r_pending    <= {BUF_SIZE{1'b0}};
                    r_rf_we      <= 2'b00;
                    r_free_valid <= 2'b00;
                    r_st_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign rf_we       = r_rf_we;
    assign rf_addr     = r_rf_addr;
    assign rf_data     = r_rf_data;
    assign free_valid  = r_free_valid;
    assign free_index  = r_free_index;
    assign st_valid    = r_st_valid;
    assign st_addr     = r_st_addr;
    assign st_data     = r_st_data;
    assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_commit_unit
// Directed scenarios plus randomized traffic against a reference model that
// ranks entries by scanning tags from oldest to youngest. The bench plays the
// dispatch stage: entries it sees released are cleared from its buffer copy one
// cycle after release, as a real buffer would update.
// -----------------------------------------------------------------------------
module tb_commit_unit;

    localparam int NB = 16;
    localparam int EW = 78;

    localparam logic [1:0] NU = 2'd0, NE = 2'd1, EX = 2'd2;
    localparam logic [1:0] ALU = 2'd0, STO = 2'd1, BRA = 2'd2, LDI = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              st_ready;
    logic [NB*EW-1:0]  entries_all;
    logic [1:0]        rf_we;
    logic [9:0]        rf_addr;
    logic [63:0]       rf_data;
    logic [1:0]        free_valid;
    logic [7:0]        free_index;
    logic              st_valid;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic [31:0]       retired_cnt;

    commit_unit dut (
        .clk(clk), .rst_n(rst_n), .entries_all(entries_all), .flush(flush),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .free_valid(free_valid), .free_index(free_index),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // bench copy of the reservation buffer
    logic [1:0]  b_state [NB];
    logic [1:0]  b_op    [NB];
    logic [4:0]  b_tag   [NB];
    logic [4:0]  b_dest  [NB];
    logic [31:0] b_res   [NB];
    logic [31:0] b_vk    [NB];

    // reference model state and expectations
    bit          m_wait;
    bit [NB-1:0] m_pend;
    int          m_st_idx;
    logic [31:0] m_st_addr, m_st_data;
    logic [31:0] m_cnt;
    bit [NB-1:0] f_prev;
    bit [NB-1:0] f_now;
    bit          e_reset;
    bit [1:0]    e_we, e_fv;
    bit          e_stv;
    logic [4:0]  e_addr [2];
    logic [31:0] e_data [2];
    int          e_fi   [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input int idx, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] tag, input logic [4:0] dest,
                       input logic [31:0] res, input logic [31:0] vk);
        b_state[idx] = st; b_op[idx] = op; b_tag[idx] = tag;
        b_dest[idx] = dest; b_res[idx] = res; b_vk[idx] = vk;
    endtask

    task automatic retire(input int k, input int idx);
        e_fv[k]   = 1'b1;
        e_fi[k]   = idx;
        e_we[k]   = (b_op[idx] != STO) && (b_op[idx] != BRA) && (b_dest[idx] != 5'd0);
        e_addr[k] = b_dest[idx];
        e_data[k] = b_res[idx];
        m_cnt     = m_cnt + 32'd1;
        f_now[idx] = 1'b1;
    endtask

    // Decide what the commit stage must show after the coming edge.
    task automatic model_step();
        int o, s;
        e_reset = 1'b0; e_we = 2'b00; e_fv = 2'b00; e_stv = 1'b0; f_now = '0;
        if (!rst_n) begin
            e_reset = 1'b1; m_wait = 1'b0; m_pend = '0; m_cnt = 32'd0;
            m_st_addr = 32'd0; m_st_data = 32'd0;
        end else if (flush) begin
            m_wait = 1'b0; m_pend = '0;
        end else if (m_wait) begin
            if (st_ready) begin
                e_fv[0] = 1'b1; e_fi[0] = m_st_idx; m_cnt = m_cnt + 32'd1;
                f_now[m_st_idx] = 1'b1; m_wait = 1'b0;
            end else begin
                e_stv = 1'b1;
            end
            m_pend = f_now;
        end else begin
            o = -1; s = -1;
            for (int t = 2*NB-1; t >= 0; t--)
                for (int i = 0; i < NB; i++)
                    if (b_state[i] != NU && !m_pend[i] && b_tag[i] == t) begin
                        if (o < 0) o = i;
                        else if (s < 0) s = i;
                    end
            if (o >= 0 && b_state[o] == EX) begin
                if (b_op[o] == STO) begin
                    e_stv = 1'b1; m_wait = 1'b1; m_st_idx = o;
                    m_st_addr = b_res[o]; m_st_data = b_vk[o];
                end else begin
                    retire(0, o);
                    if (s >= 0 && b_state[s] == EX && b_op[s] != STO) retire(1, s);
                end
            end
            m_pend = f_now;
        end
    endtask

    task automatic compare();
        check_eq("rf_we", rf_we, e_we);
        check_eq("free_valid", free_valid, e_fv);
        check_eq("st_valid", st_valid, e_stv);
        check_eq("retired_cnt", retired_cnt, m_cnt);
        for (int k = 0; k < 2; k++) begin
            if (e_we[k]) begin
                check_eq("rf_addr", rf_addr[k*5 +: 5], e_addr[k]);
                check_eq("rf_data", rf_data[k*32 +: 32], e_data[k]);
            end
            if (e_fv[k]) check_eq("free_index", free_index[k*4 +: 4], e_fi[k]);
        end
        if (e_stv) begin
            check_eq("st_addr", st_addr, m_st_addr);
            check_eq("st_data", st_data, m_st_data);
        end
        if (e_reset) begin
            check_eq("rst_rf_addr", rf_addr, 0);
            check_eq("rst_rf_data", rf_data, 0);
            check_eq("rst_free_index", free_index, 0);
            check_eq("rst_st_addr", st_addr, 0);
            check_eq("rst_st_data", st_data, 0);
        end
    endtask

    // One clock: drive at negedge, check just after the rising edge.
    task automatic cycle();
        for (int i = 0; i < NB; i++)
            entries_all[i*EW +: EW] = {b_vk[i], b_res[i], b_dest[i], b_tag[i], b_op[i], b_state[i]};
        model_step();
        @(posedge clk);
        #1;
        compare();
        for (int i = 0; i < NB; i++)
            if (f_prev[i]) b_state[i] = NU;
        f_prev = f_now;
        @(negedge clk);
    endtask

    function automatic bit any_used();
        for (int i = 0; i < NB; i++)
            if (b_state[i] != NU) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int guard;
        guard = 0;
        flush = 1'b0; st_ready = 1'b1;
        for (int i = 0; i < NB; i++)
            if (b_state[i] == NE) b_state[i] = EX;
        while (any_used() && guard < 60) begin
            cycle();
            guard++;
        end
        check_eq("drain_bound", guard < 60, 1);
        cycle();
        cycle();
    endtask

    initial begin
        int t, idx, cnt;
        rst_n = 1'b0; flush = 1'b0; st_ready = 1'b0;
        entries_all = '0;
        m_wait = 1'b0; m_pend = '0; m_cnt = 32'd0; m_st_idx = 0;
        m_st_addr = 32'd0; m_st_data = 32'd0; f_prev = '0; f_now = '0;
        for (int i = 0; i < NB; i++) put(i, NU, ALU, 5'd0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);

        // 1: reset held two cycles with executed entries present
        put(3, EX, ALU, 5'd15, 5'd3, 32'hA5, 32'd0);
        put(7, EX, ALU, 5'd14, 5'd4, 32'h5A, 32'd0);
        cycle();
        cycle();
        check_eq("t1_valids", {rf_we, free_valid, st_valid}, 0);
        check_eq("t1_cnt", retired_cnt, 0);

        // 2: two executed ALU ops retire together, then are not re-freed
        rst_n = 1'b1;
        cycle();
        check_eq("t2_we", rf_we, 2'b11);
        check_eq("t2_addr", rf_addr, {5'd4, 5'd3});
        check_eq("t2_data", rf_data, {32'h5A, 32'hA5});
        check_eq("t2_free", {free_index, free_valid}, {4'd7, 4'd3, 2'b11});
        check_eq("t2_cnt", retired_cnt, 2);
        cycle();
        check_eq("t2_no_refree", free_valid, 2'b00);
        drain();

        // 3: oldest not executed blocks the younger one
        put(0, NE, ALU, 5'd15, 5'd1, 32'h11, 32'd0);
        put(5, EX, ALU, 5'd14, 5'd2, 32'h22, 32'd0);
        cycle(); cycle(); cycle();
        check_eq("t3_blocked", free_valid, 2'b00);
        b_state[0] = EX;
        cycle();
        check_eq("t3_both", free_valid, 2'b11);
        drain();

        // 4: store held until ready, then the younger ALU op commits
        st_ready = 1'b0;
        put(2, EX, STO, 5'd15, 5'd0, 32'h100, 32'hDEAD);
        put(9, EX, ALU, 5'd14, 5'd6, 32'h77, 32'd0);
        cycle();
        check_eq("t4_issue", {st_valid, st_addr, st_data[15:0]}, {1'b1, 32'h100, 16'hDEAD});
        cycle(); cycle(); cycle();
        check_eq("t4_held", {st_valid, free_valid}, {1'b1, 2'b00});
        st_ready = 1'b1;
        cycle();
        check_eq("t4_free", {st_valid, free_valid, free_index[3:0]}, {1'b0, 2'b01, 4'd2});
        st_ready = 1'b0;
        cycle();
        check_eq("t4_alu", {rf_we, rf_addr[4:0]}, {2'b01, 5'd6});
        drain();

        // 5: flush while waiting on a store
        st_ready = 1'b0;
        put(4, EX, STO, 5'd13, 5'd0, 32'h200, 32'hBEEF);
        cycle(); cycle();
        flush = 1'b1; st_ready = 1'b1;
        cycle();
        check_eq("t5_flush", {st_valid, free_valid}, 0);
        flush = 1'b0;
        drain();

        // reset in the middle of a store
        st_ready = 1'b0;
        put(8, EX, STO, 5'd12, 5'd0, 32'h300, 32'hCAFE);
        cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        check_eq("rst_mid_store", {st_valid, free_valid, retired_cnt}, 0);
        rst_n = 1'b1;
        drain();

        // 6: branch and Dest=0 retire without register writes
        put(1, EX, BRA, 5'd15, 5'd7, 32'h44, 32'd0);
        put(6, EX, ALU, 5'd14, 5'd0, 32'h55, 32'd0);
        cycle();
        check_eq("t6_free", {free_valid, rf_we}, {2'b11, 2'b00});
        drain();

        // randomized traffic
        for (int it = 0; it < 1500; it++) begin
            if (!any_used() && f_prev == '0) begin
                cnt = $urandom_range(8, 1);
                t = $urandom_range(31, 16);
                for (int k = 0; k < cnt; k++) begin
                    idx = $urandom_range(NB-1, 0);
                    while (b_state[idx] != NU) idx = (idx + 1) % NB;
                    put(idx, ($urandom_range(1, 0) == 1) ? EX : NE, 2'($urandom_range(3, 0)),
                        5'(t), 5'($urandom_range(31, 0)), $urandom, $urandom);
                    t = t - $urandom_range(2, 1);
                end
            end
            for (int i = 0; i < NB; i++)
                if (b_state[i] == NE && $urandom_range(2, 0) == 0) b_state[i] = EX;
            st_ready = ($urandom_range(1, 0) == 1);
            flush    = ($urandom_range(39, 0) == 0);
            cycle();
        end
        flush = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
